// File: rtl/wt_cache_pkg.sv
// Shared L1.5 request types and defaults for the write-through cache path.
// Provides l15_req_t and the default request queue depth.
package wt_cache_pkg;

  localparam int unsigned L15ReqQueueDepth = 4;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic        nc;
    logic [2:0]  size;
    logic [1:0]  threadid;
    logic        prefetch;
    logic        invalidate_cacheline;
    logic        blockstore;
    logic        blockinitstore;
    logic [1:0]  l1rplway;
    logic [39:0] address;
    logic [63:0] data;
  } l15_req_t;

endpackage

// File: rtl/ariane_l15_sync_fifo.sv
// Registered-storage FIFO, sync active-low reset, no fall-through.
// Ports: i_push/i_data write, i_pop read, o_data head, o_full/o_empty/o_occupancy.
module ariane_l15_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_data,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_occupancy
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             w_msb_diff;
  logic             w_idx_eq;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not cleared on reset; pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // Extra pointer bit tells a wrapped (full) queue from an empty one.
  assign w_msb_diff  = r_wptr[AW] != r_rptr[AW];
  assign w_idx_eq    = r_wptr[AW-1:0] == r_rptr[AW-1:0];
  assign o_full      = w_msb_diff & w_idx_eq;
  assign o_empty     = ~w_msb_diff & w_idx_eq;
  assign o_occupancy = r_wptr - r_rptr;
  assign o_data      = r_mem[r_rptr[AW-1:0]];

  a_push_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(i_push && o_full)
  ) else $error("push when full");

  a_pop_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(i_pop && o_empty)
  ) else $error("pop when empty");

endmodule

// File: rtl/ariane_l15_req_queue.sv
// Core-to-L1.5 request queue: buffers core requests, issues in order.
// Ports: core_val_i/core_data_i/core_ack_o in, l15_val_o/l15_data_o/l15_ack_i out.
module ariane_l15_req_queue
  import wt_cache_pkg::*;
#(
  parameter int unsigned ReqWidth = $bits(wt_cache_pkg::l15_req_t),
  parameter int unsigned Depth    = wt_cache_pkg::L15ReqQueueDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_en_i,
  input  logic                   core_val_i,
  input  logic [ReqWidth-1:0]    core_data_i,
  output logic                   core_ack_o,
  output logic                   l15_val_o,
  output logic [ReqWidth-1:0]    l15_data_o,
  input  logic                   l15_ack_i,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic                   full_o,
  output logic                   empty_o
);

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full is checked before any same-cycle pop, so a slot freed
  // this cycle only becomes usable next cycle.
  assign w_push     = rst_ni & core_val_i & ~w_full;
  assign core_ack_o = w_push;
  assign l15_val_o  = issue_en_i & ~w_empty;
  assign w_pop      = l15_val_o & l15_ack_i;
  assign full_o     = w_full;
  assign empty_o    = w_empty;

  ariane_l15_sync_fifo #(
    .Width (ReqWidth),
    .Depth (Depth)
  ) i_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_data      (core_data_i),
    .i_pop       (w_pop),
    .o_data      (l15_data_o),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (occupancy_o)
  );

  a_core_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (core_val_i && !core_ack_o) |=>
      (!core_val_i || $stable(core_data_i))
  ) else $error("core_data_i changed while unacked");

endmodule

// File: tb/tb_ariane_l15_req_queue.sv
// Randomized and directed bench for ariane_l15_req_queue.
// Checks every cycle against a queue-based reference model.
module tb_ariane_l15_req_queue;

  localparam int unsigned W  = $bits(wt_cache_pkg::l15_req_t);
  localparam int unsigned D  = 4;
  localparam int unsigned OW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           issue_en = 1'b0;
  logic           core_val = 1'b0;
  logic [W-1:0]   core_data = '0;
  logic           core_ack;
  logic           l15_val;
  logic [W-1:0]   l15_data;
  logic           l15_ack = 1'b0;
  logic [OW-1:0]  occ;
  logic           full;
  logic           empty;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  bit           last_ack = 1'b0;

  always #5 clk = ~clk;

  ariane_l15_req_queue dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .issue_en_i  (issue_en),
    .core_val_i  (core_val),
    .core_data_i (core_data),
    .core_ack_o  (core_ack),
    .l15_val_o   (l15_val),
    .l15_data_o  (l15_data),
    .l15_ack_i   (l15_ack),
    .occupancy_o (occ),
    .full_o      (full),
    .empty_o     (empty)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // One clock: drive at negedge, check model, update model at posedge.
  task automatic step(input logic rst, input logic en, input logic ack,
                      input logic want, input logic [W-1:0] d);
    bit e_ack;
    bit e_val;
    int n;
    @(negedge clk);
    if (last_ack) core_val = 1'b0;
    rst_n    = rst;
    issue_en = en;
    l15_ack  = ack;
    if (!core_val && want) begin
      core_val  = 1'b1;
      core_data = d;
    end
    #1;
    n     = mq.size();
    e_ack = rst && core_val && (n != D);
    e_val = en && (n != 0);
    chk("core_ack", W'(core_ack), W'(e_ack));
    chk("l15_val", W'(l15_val), W'(e_val));
    chk("occupancy", W'(occ), W'(n));
    chk("full", W'(full), W'(n == D));
    chk("empty", W'(empty), W'(n == 0));
    if (e_val) chk("l15_data", l15_data, mq[0]);
    @(posedge clk);
    if (!rst) begin
      mq.delete();
    end else begin
      if (e_val && ack) void'(mq.pop_front());
      if (e_ack) mq.push_back(core_data);
    end
    last_ack = e_ack;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, '0);
  endtask

  initial begin
    step(0, 1, 0, 1, W'(8'h11));
    step(0, 1, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    drain();
    // single request with ack held high
    step(1, 1, 1, 1, W'(8'hA5));
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    // fill, stall 5th, pop while full, then accept
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 1, W'(i));
    step(1, 1, 0, 1, W'(5));
    step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    step(1, 1, 0, 0, '0);
    drain();
    // steady push/pop at occupancy 2
    step(1, 1, 0, 1, rnd());
    step(1, 1, 0, 1, rnd());
    for (int i = 0; i < 10; i++) step(1, 1, 1, 1, rnd());
    drain();
    // issue disabled, then enabled
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, rnd());
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, '0);
    // reset with stored entries
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, rnd());
    step(0, 1, 0, 0, '0);
    step(1, 1, 1, 1, W'(8'h5A));
    drain();
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           rnd());
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ariane_l15_req_queue.md
ARIANE_L15_REQ_QUEUE -- requirements
Module: ariane_l15_req_queue

Interface
REQ-001 Parameter ReqWidth, default $bits(wt_cache_pkg::l15_req_t), width of one opaque request payload.
REQ-002 Parameter Depth, default 4, queue entries; power of two, >= 2.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 issue_en_i  input  1  downstream issue enable; low holds l15_val_o low, queue still accepts.
REQ-006 core_val_i  input  1  core request valid; core holds val and data stable until accepted.
REQ-007 core_data_i  input  ReqWidth  core request payload.
REQ-008 core_ack_o  output  1  request accepted this cycle.
REQ-009 l15_val_o  output  1  head request valid toward L1.5.
REQ-010 l15_data_o  output  ReqWidth  head request payload.
REQ-011 l15_ack_i  input  1  L1.5 accepts head this cycle.
REQ-012 occupancy_o  output  $clog2(Depth)+1  stored entry count.
REQ-013 full_o  output  1  occupancy == Depth.
REQ-014 empty_o  output  1  occupancy == 0.

Function
REQ-015 core_ack_o SHALL equal core_val_i AND NOT full_o, combinational; no path from l15_ack_i to core_ack_o.
REQ-016 On core_ack_o, core_data_i SHALL be written at write pointer; write pointer SHALL increment modulo Depth.
REQ-017 l15_val_o SHALL equal NOT empty_o AND issue_en_i; l15_data_o SHALL be the head entry, registered storage, no bypass.
REQ-018 Enqueue-to-issue latency SHALL be 1 cycle: request accepted in cycle N into empty queue appears on l15_val_o in N+1.
REQ-019 Pop SHALL occur when l15_val_o AND l15_ack_i; read pointer SHALL increment modulo Depth.
REQ-020 l15_ack_i while l15_val_o low SHALL be ignored (no pop, no pointer change).
REQ-021 l15_data_o SHALL stay stable while l15_val_o high and no pop occurs, including across issue_en_i toggling.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; both pointers advance.
REQ-023 When full, push SHALL be refused even if a pop occurs the same cycle; push accepted next cycle.
REQ-024 Pointers SHALL carry $clog2(Depth)+1 bits; full/empty derived from MSB-differ / equal compare.
REQ-025 Requests SHALL leave strictly in acceptance order; no drop, no duplication.
REQ-026 occupancy_o SHALL update in the cycle after push/pop.

Reset
REQ-027 While rst_ni low at a clock edge: pointers and occupancy SHALL clear to 0; next cycle l15_val_o=0, empty_o=1, full_o=0, occupancy_o=0.
REQ-028 core_ack_o SHALL be 0 during reset cycles regardless of core_val_i.
REQ-029 Reset mid-operation SHALL discard all stored entries; storage array need not be cleared.

Structure
REQ-030 l15_req_t and the default Depth constant (L15ReqQueueDepth=4) SHALL live in wt_cache_pkg.
REQ-031 Storage and pointers SHALL be one sub-module, ariane_l15_sync_fifo (synchronous active-low reset, no fall-through); the top adds gating and ack logic.
REQ-032 Assertions SHALL flag push-when-full, pop-when-empty, and core_data_i change while core_val_i high and unacked.

Verification
REQ-033 Single request 0xA5 at cycle 10, l15_ack_i held high -> core_ack_o at 10, l15_val_o with 0xA5 at 11 only, empty_o=1 at 12.
REQ-034 Fill Depth=4 with 1..4, l15_ack_i=0 -> full_o=1 after 4th push; 5th request stalled (core_ack_o=0) until one pop, then accepted next cycle; output order 1,2,3,4,5.
REQ-035 Full queue, push and pop same cycle -> push refused, pop done, occupancy 4->3.
REQ-036 Occupancy 2, simultaneous push/pop for 10 cycles -> occupancy stays 2, pointers wrap, order preserved.
REQ-037 issue_en_i=0 with 3 entries and l15_ack_i=1 -> l15_val_o=0, no pops; issue_en_i=1 -> 3 pops in 3 consecutive cycles.
REQ-038 rst_ni=0 for 1 cycle with 3 entries -> next cycle empty_o=1, occupancy_o=0, l15_val_o=0; post-reset request issues normally.
